// File: rtl/sprite_pos_fetcher.sv
`timescale 1ns/1ps
// Once per frame, fetches the six sprite/player position words from memory port A.
// The words are presented to the renderer as registers that all update on the same edge.
module sprite_pos_fetcher #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NUM_POS      = 6,
    parameter int unsigned BASE_ADDR    = 6000,
    parameter int unsigned ADDR_STRIDE  = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd_en,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] mx,
    output logic [WIDTH-1:0] my,
    output logic [WIDTH-1:0] p1x,
    output logic [WIDTH-1:0] p1y,
    output logic [WIDTH-1:0] p2x,
    output logic [WIDTH-1:0] p2y,
    output logic             positions_valid,
    output logic             busy,
    output logic             frame_overrun
);

    localparam int unsigned CNT_MAX = (NUM_POS > READ_LATENCY) ? NUM_POS : READ_LATENCY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_COMMIT
    } state_t;

    localparam cnt_t             LAST_ISSUE = cnt_t'(NUM_POS - 1);
    localparam cnt_t             LAST_DRAIN = cnt_t'(READ_LATENCY - 1);
    localparam logic [WIDTH-1:0] BASE       = WIDTH'(BASE_ADDR);
    localparam logic [WIDTH-1:0] STRIDE     = WIDTH'(ADDR_STRIDE);

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;

    // Return-tag pipeline: stage READ_LATENCY-1 says which word mem_data carries now.
    logic [READ_LATENCY-1:0] tag_vld_q;
    cnt_t                    tag_idx_q [READ_LATENCY];

    logic [WIDTH-1:0] shadow_q [NUM_POS];
    logic [WIDTH-1:0] pos_q    [NUM_POS];
    logic             valid_q;
    logic             overrun_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_rd_en = 1'b0;
        mem_addr  = BASE;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                mem_rd_en = 1'b1;
                mem_addr  = BASE + WIDTH'(cnt_q) * STRIDE;
                if (cnt_q == LAST_ISSUE) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    state_d = ST_COMMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                tag_idx_q[i] <= '0;
            end
            for (int k = 0; k < int'(NUM_POS); k++) begin
                shadow_q[k] <= '0;
                pos_q[k]    <= '0;
            end
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tag_vld_q[0] <= mem_rd_en;
            tag_idx_q[0] <= cnt_q;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end

            if (tag_vld_q[READ_LATENCY-1]) begin
                for (int k = 0; k < int'(NUM_POS); k++) begin
                    if (tag_idx_q[READ_LATENCY-1] == cnt_t'(k)) begin
                        shadow_q[k] <= mem_data;
                    end
                end
            end

            // All visible words load together so the renderer never sees a mixed frame.
            if (state_q == ST_COMMIT) begin
                for (int k = 0; k < int'(NUM_POS); k++) begin
                    pos_q[k] <= shadow_q[k];
                end
                valid_q <= 1'b1;
            end

            if (frame_start && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign mx              = pos_q[0];
    assign my              = pos_q[1];
    assign p1x             = pos_q[2];
    assign p1y             = pos_q[3];
    assign p2x             = pos_q[4];
    assign p2y             = pos_q[5];
    assign positions_valid = valid_q;
    assign frame_overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_pos_fetcher.sv
`timescale 1ns/1ps
// Bench for sprite_pos_fetcher: instance A uses default parameters, instance B uses
// READ_LATENCY=3 with a base address that wraps past 0xFFFF.
module tb_sprite_pos_fetcher;

    localparam int N      = 6;
    localparam int STRIDE = 4;

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    function automatic int base_of(input int inst);
        return (inst == 0) ? 6000 : 'hFFF8;
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        fs     [2];
    logic [15:0] d_addr [2];
    logic [15:0] d_data [2];
    logic [15:0] d_pos  [2][6];
    logic        d_rden [2];
    logic        d_valid[2];
    logic        d_busy [2];
    logic        d_ovr  [2];

    always #5 clk = ~clk;

    sprite_pos_fetcher #(
        .WIDTH(16), .NUM_POS(6), .BASE_ADDR(6000), .ADDR_STRIDE(4), .READ_LATENCY(1)
    ) dut_a (
        .clk(clk), .reset(reset), .frame_start(fs[0]),
        .mem_addr(d_addr[0]), .mem_rd_en(d_rden[0]), .mem_data(d_data[0]),
        .mx(d_pos[0][0]), .my(d_pos[0][1]), .p1x(d_pos[0][2]), .p1y(d_pos[0][3]),
        .p2x(d_pos[0][4]), .p2y(d_pos[0][5]),
        .positions_valid(d_valid[0]), .busy(d_busy[0]), .frame_overrun(d_ovr[0])
    );

    sprite_pos_fetcher #(
        .WIDTH(16), .NUM_POS(6), .BASE_ADDR('hFFF8), .ADDR_STRIDE(4), .READ_LATENCY(3)
    ) dut_b (
        .clk(clk), .reset(reset), .frame_start(fs[1]),
        .mem_addr(d_addr[1]), .mem_rd_en(d_rden[1]), .mem_data(d_data[1]),
        .mx(d_pos[1][0]), .my(d_pos[1][1]), .p1x(d_pos[1][2]), .p1y(d_pos[1][3]),
        .p2x(d_pos[1][4]), .p2y(d_pos[1][5]),
        .positions_valid(d_valid[1]), .busy(d_busy[1]), .frame_overrun(d_ovr[1])
    );

    // Shared memory; each port returns data READ_LATENCY cycles after the address.
    logic [15:0] mem [65536];
    logic [15:0] rp_a = '0;
    logic [15:0] rp_b [3] = '{default: '0};

    always @(posedge clk) begin
        rp_a    <= mem[d_addr[0]];
        rp_b[0] <= mem[d_addr[1]];
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign d_data[0] = rp_a;
    assign d_data[1] = rp_b[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
    endtask

    // Timeline model: age counts cycles since the accepted frame_start (0 = idle).
    // Word k is whatever memory held at the cycle its address was issued.
    int          age      [2];
    logic [15:0] snap     [2][6];
    logic [15:0] exp_pos  [2][6];
    logic        exp_valid[2];
    logic        exp_ovr  [2];
    logic [15:0] e_addr;
    logic        e_rden;
    logic        e_busy;
    int          lat;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            lat = lat_of(i);
            if (!reset) begin
                age[i]       = 0;
                exp_valid[i] = 1'b0;
                exp_ovr[i]   = 1'b0;
                for (int k = 0; k < N; k++) exp_pos[i][k] = '0;
            end
            e_rden = (age[i] >= 1) && (age[i] <= N);
            e_busy = (age[i] >= 1);
            e_addr = e_rden ? 16'(base_of(i) + (age[i] - 1) * STRIDE) : 16'(base_of(i));

            chk("mem_addr", i, 32'(d_addr[i]), 32'(e_addr));
            chk("mem_rd_en", i, 32'(d_rden[i]), 32'(e_rden));
            chk("busy", i, 32'(d_busy[i]), 32'(e_busy));
            chk("positions_valid", i, 32'(d_valid[i]), 32'(exp_valid[i]));
            chk("frame_overrun", i, 32'(d_ovr[i]), 32'(exp_ovr[i]));
            for (int k = 0; k < N; k++) begin
                chk($sformatf("pos%0d", k), i, 32'(d_pos[i][k]), 32'(exp_pos[i][k]));
            end

            if (reset) begin
                if (e_rden) snap[i][age[i]-1] = mem[e_addr];
                if (fs[i] && age[i] != 0) exp_ovr[i] = 1'b1;
                if (age[i] == N + lat + 1) begin
                    for (int k = 0; k < N; k++) exp_pos[i][k] = snap[i][k];
                    exp_valid[i] = 1'b1;
                    age[i]       = 0;
                end else if (age[i] != 0) begin
                    age[i]++;
                end else if (fs[i]) begin
                    age[i] = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hand-computed pattern: word k must equal first + k*step.
    task automatic lit_pos(input string nm, input int inst, input logic [15:0] first, input logic [15:0] step);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_w%0d", nm, k), inst, 32'(d_pos[inst][k]), 32'(16'(first + 16'(k) * step)));
        end
    endtask

    task automatic set_words(input logic [15:0] first, input logic [15:0] step);
        for (int k = 0; k < N; k++) mem[6000 + 4 * k] = 16'(first + 16'(k) * step);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        fs[0] = 1'b0;
        fs[1] = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'hA5C3;
        set_words(16'h0010, 16'h0010);
        mem[16'hFFF8] = 16'h1111;
        mem[16'hFFFC] = 16'h2222;
        mem[16'h0000] = 16'h3333;
        mem[16'h0004] = 16'h4444;
        mem[16'h0008] = 16'h5555;
        mem[16'h000C] = 16'h6666;
        #2 reset = 1'b0;

        // Reset state
        tick(3);
        reset = 1'b1;
        @(negedge clk);
        lit_pos("rst", 0, 16'h0000, 16'h0000);
        chk("rst_valid", 0, 32'(d_valid[0]), 32'd0);
        chk("rst_busy", 0, 32'(d_busy[0]), 32'd0);
        chk("rst_addr", 0, 32'(d_addr[0]), 32'd6000);
        chk("rst_rden", 0, 32'(d_rden[0]), 32'd0);
        chk("rst_addr", 1, 32'(d_addr[1]), 32'h0000FFF8);
        tick(2);

        // Basic fetch plus atomicity: word 6020 changes after capture, before commit
        fs[0] = 1'b1;
        tick(1);
        fs[0] = 1'b0;
        @(negedge clk);
        chk("f1_addr_c1", 0, 32'(d_addr[0]), 32'd6000);
        chk("f1_rden_c1", 0, 32'(d_rden[0]), 32'd1);
        tick(5);
        @(negedge clk);
        chk("f1_addr_c6", 0, 32'(d_addr[0]), 32'd6020);
        tick(2);
        mem[6020] = 16'hBEEF;
        @(negedge clk);
        chk("f1_busy_c8", 0, 32'(d_busy[0]), 32'd1);
        chk("f1_p2y_c8", 0, 32'(d_pos[0][5]), 32'd0);
        tick(1);
        @(negedge clk);
        lit_pos("f1_c9", 0, 16'h0010, 16'h0010);
        chk("f1_valid_c9", 0, 32'(d_valid[0]), 32'd1);
        chk("f1_busy_c9", 0, 32'(d_busy[0]), 32'd0);

        // Overrun: second pulse in cycle 4 is ignored
        set_words(16'h0101, 16'h0101);
        tick(2);
        fs[0] = 1'b1;
        tick(1);
        fs[0] = 1'b0;
        tick(3);
        fs[0] = 1'b1;
        tick(1);
        fs[0] = 1'b0;
        @(negedge clk);
        chk("ovr_c5", 0, 32'(d_ovr[0]), 32'd1);
        tick(3);
        @(negedge clk);
        chk("ovr_mx_c8", 0, 32'(d_pos[0][0]), 32'h0010);
        tick(1);
        @(negedge clk);
        lit_pos("ovr_c9", 0, 16'h0101, 16'h0101);
        chk("ovr_busy_c9", 0, 32'(d_busy[0]), 32'd0);
        tick(1);
        @(negedge clk);
        chk("ovr_busy_c10", 0, 32'(d_busy[0]), 32'd0);
        chk("ovr_rden_c10", 0, 32'(d_rden[0]), 32'd0);

        // Clean fetch: overrun stays sticky
        set_words(16'h0010, 16'h0010);
        tick(2);
        fs[0] = 1'b1;
        tick(1);
        fs[0] = 1'b0;
        tick(8);
        @(negedge clk);
        lit_pos("f3_c9", 0, 16'h0010, 16'h0010);
        chk("f3_ovr", 0, 32'(d_ovr[0]), 32'd1);

        // Reset in cycle 5 of a fetch
        tick(2);
        fs[0] = 1'b1;
        tick(1);
        fs[0] = 1'b0;
        tick(4);
        reset = 1'b0;
        @(negedge clk);
        lit_pos("mid_rst", 0, 16'h0000, 16'h0000);
        chk("mid_rst_valid", 0, 32'(d_valid[0]), 32'd0);
        chk("mid_rst_busy", 0, 32'(d_busy[0]), 32'd0);
        chk("mid_rst_ovr", 0, 32'(d_ovr[0]), 32'd0);
        chk("mid_rst_rden", 0, 32'(d_rden[0]), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        fs[0] = 1'b1;
        tick(1);
        fs[0] = 1'b0;
        tick(8);
        @(negedge clk);
        lit_pos("f5_c9", 0, 16'h0010, 16'h0010);
        chk("f5_valid", 0, 32'(d_valid[0]), 32'd1);

        // Latency 3 with address wrap; pulse during COMMIT is an overrun
        tick(2);
        fs[1] = 1'b1;
        tick(1);
        fs[1] = 1'b0;
        @(negedge clk);
        chk("b_addr_c1", 1, 32'(d_addr[1]), 32'h0000FFF8);
        chk("b_rden_c1", 1, 32'(d_rden[1]), 32'd1);
        tick(2);
        @(negedge clk);
        chk("b_addr_c3", 1, 32'(d_addr[1]), 32'h00000000);
        tick(3);
        @(negedge clk);
        chk("b_addr_c6", 1, 32'(d_addr[1]), 32'h0000000C);
        tick(4);
        fs[1] = 1'b1;
        @(negedge clk);
        chk("b_busy_c10", 1, 32'(d_busy[1]), 32'd1);
        chk("b_mx_c10", 1, 32'(d_pos[1][0]), 32'd0);
        tick(1);
        fs[1] = 1'b0;
        @(negedge clk);
        lit_pos("b_c11", 1, 16'h1111, 16'h1111);
        chk("b_valid_c11", 1, 32'(d_valid[1]), 32'd1);
        chk("b_busy_c11", 1, 32'(d_busy[1]), 32'd0);
        chk("b_ovr_c11", 1, 32'(d_ovr[1]), 32'd1);
        tick(1);
        @(negedge clk);
        chk("b_busy_c12", 1, 32'(d_busy[1]), 32'd0);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sprite_pos_fetcher.md
Name: sprite_pos_fetcher

Overview:
- Once per frame, reads the six sprite/player position words (mx, my, p1x, p1y, p2x, p2y) from the read-only VGA port (port A) of the dual-port memory.
- Presents the six words to the vga block as stable, atomically updated registers.
- Sits between mem port A and the vga renderer.
- Replaces the free-running address counter/mux path with a frame-synchronised, tear-free fetch.

Parameters:
- WIDTH, 16, data and address width.
- NUM_POS, 6, number of position words fetched per frame (fixed order: mx, my, p1x, p1y, p2x, p2y).
- BASE_ADDR, 6000, address of the first word (mx).
- ADDR_STRIDE, 4, address increment between consecutive words.
- READ_LATENCY, 1, cycles from mem_addr presented to mem_data valid (legal values 1..3).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse from vga at start of vertical blank.
- mem_addr  out  WIDTH  address to mem port A.
- mem_rd_en  out  1  high in cycles where mem_addr is a valid fetch address.
- mem_data  in  WIDTH  port A read data.
- mx, my, p1x, p1y, p2x, p2y  out  WIDTH each  committed position words.
- positions_valid  out  1  high once the first full fetch has committed.
- busy  out  1  high from the first issue cycle through the commit cycle.
- frame_overrun  out  1  sticky; set when frame_start arrives while busy.

Behaviour:
Reset (reset=0, async):
- All position outputs = 0.
- positions_valid = 0, busy = 0, frame_overrun = 0, mem_rd_en = 0, mem_addr = BASE_ADDR.
- FSM in IDLE; shadow registers cleared.
- Reset asserted mid-fetch aborts the fetch; no partial commit.

FSM states: IDLE -> ISSUE -> DRAIN -> COMMIT -> IDLE.
- IDLE: mem_rd_en=0, mem_addr=BASE_ADDR. frame_start=1 moves to ISSUE on the next edge.
- ISSUE: lasts NUM_POS cycles, index k=0..NUM_POS-1.
  - mem_addr = BASE_ADDR + k*ADDR_STRIDE, modulo 2^WIDTH.
  - mem_rd_en = 1.
  - One address is issued per cycle, back-to-back (pipelined).
- DRAIN: lasts READ_LATENCY cycles, mem_rd_en=0, mem_addr=BASE_ADDR. It completes the in-flight reads.
- Capture: a delayed index/valid pipeline of depth READ_LATENCY tags each return. The word for index k is sampled from mem_data exactly READ_LATENCY cycles after its issue cycle and written into shadow register k.
- COMMIT: one cycle. All six outputs load from the shadow registers on the same edge, so there is no partial update visible. positions_valid sets to 1 and stays 1 until reset. Returns to IDLE.

Timing: if frame_start is high in cycle 0, then:
- Issues occur in cycles 1..NUM_POS.
- The last capture is in cycle NUM_POS+READ_LATENCY.
- COMMIT is in cycle NUM_POS+READ_LATENCY+1.
- New outputs are visible from cycle NUM_POS+READ_LATENCY+2.
- Default total: frame_start to new outputs = 9 cycles.

busy: high in the ISSUE, DRAIN and COMMIT states, low in IDLE.

frame_start while busy (including in the COMMIT cycle):
- Ignored; not queued.
- frame_overrun sets to 1 and stays set until reset.
- The current fetch completes normally.

frame_start in IDLE coincident with a reset release edge: ignored; the first accepted pulse must arrive at least one cycle after reset deasserts.

Outputs hold their values between commits regardless of memory contents changing.

mem_data is not sampled outside capture slots.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> all positions 0, positions_valid=0, busy=0, mem_addr=6000, mem_rd_en=0.
- Basic fetch: memory holds 6000:0x0010, 6004:0x0020, 6008:0x0030, 6012:0x0040, 6016:0x0050, 6020:0x0060; pulse frame_start in cycle 0.
  - mem_addr = 6000, 6004, …, 6020 in cycles 1..6 with mem_rd_en=1.
  - mx..p2y = 0x0010..0x0060 from cycle 9.
  - positions_valid=1; busy falls in cycle 9.
- Atomicity: change memory word 6020 to 0xBEEF after its capture but before COMMIT -> p2y commits the captured value. All six outputs change on the same edge, and no output changes in cycles 1..8.
- Overrun: pulse frame_start again in cycle 4 of a fetch -> the fetch still commits in cycle 8, no second fetch starts, and frame_overrun=1 and stays 1 after a later clean fetch.
- Reset mid-fetch: assert reset in cycle 5 of a second fetch (previous outputs 0x0010..0x0060) -> outputs immediately 0, positions_valid=0, FSM in IDLE. The next frame_start refetches correctly.
- Latency/wrap: READ_LATENCY=3, BASE_ADDR=0xFFF8 -> addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004, 0x0008, 0x000C, data captured 3 cycles after each issue, and new outputs visible 11 cycles after frame_start.
